// File: rtl/nand_target_emu.sv
// nand_target_emu: device-side NAND flash responder for controller loopback.
// Decodes CLE/ALE/nWE/nRE strobes, holds a small page array, and drives
// ready/busy with programmable busy times.
// Optional feature: define NAND_TARGET_ERASE_EN to compile in block erase
// (0x60 + 3 row cycles + 0xD0).
module nand_target_emu #(
    parameter int         PAGE_BYTES = 16,
    parameter int         NUM_PAGES  = 4,
    parameter int         T_R        = 8,
    parameter int         T_PROG     = 32,
    parameter int         T_RST      = 4,
    parameter int         T_ERS      = 16,
    parameter logic [7:0] ID0        = 8'h2C,
    parameter logic [7:0] ID1        = 8'hDA
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       F_nCE,
    input  logic       F_CLE,
    input  logic       F_ALE,
    input  logic       F_nWE,
    input  logic       F_nRE,
    input  logic       F_nWP,
    input  logic [7:0] F_DIO_I,
    output logic [7:0] F_DIO_O,
    output logic       F_DIO_OE,
    output logic       F_nRB
);
    localparam int CB    = $clog2(PAGE_BYTES);
    localparam int PB    = $clog2(NUM_PAGES);
    localparam int TM0   = (T_R > T_PROG) ? T_R : T_PROG;
    localparam int TM1   = (T_RST > T_ERS) ? T_RST : T_ERS;
    localparam int TMAX  = (TM0 > TM1) ? TM0 : TM1;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, DIN, BUSY, DOUT_PAGE, DOUT_ID, DOUT_STAT
    } state_t;

    state_t          state, next_st;
    logic            nwe_q, nre_q;
    logic [7:0]      cmd;
    logic [2:0]      acnt;
    logic [CB-1:0]   col;
    logic [PB-1:0]   page;
    logic [1:0]      id_ptr;
    logic            fail;
    logic [TW-1:0]   timer;
    logic            copy_on, copy_ers;
    logic [CB:0]     cp_idx;
    logic [7:0]      page_reg [PAGE_BYTES];
    logic [7:0]      mem [NUM_PAGES][PAGE_BYTES];
    logic [7:0]      rd_byte;

    logic we_stb, cmd_stb, addr_stb, data_stb, re_fall, re_rise, busy, dout, copy_now;

    assign we_stb   = !nwe_q && F_nWE && !F_nCE;
    assign cmd_stb  = we_stb && F_CLE && !F_ALE;
    assign addr_stb = we_stb && F_ALE && !F_CLE;
    assign data_stb = we_stb && !F_CLE && !F_ALE;
    assign re_fall  = nre_q && !F_nRE && !F_nCE;
    assign re_rise  = !nre_q && F_nRE && !F_nCE;
    assign busy     = (timer != '0);
    assign dout     = (state == DOUT_PAGE) || (state == DOUT_ID) || (state == DOUT_STAT);
    // One array byte per busy cycle until the whole page has been copied.
    assign copy_now = busy && copy_on && !cp_idx[CB];

    // Byte presented on the next nRE falling edge, chosen by output mode.
    always_comb begin
        rd_byte = 8'h00;
        case (state)
            DOUT_PAGE: rd_byte = mem[page][col];
            DOUT_ID:   rd_byte = (id_ptr == 2'd0) ? ID0 : (id_ptr == 2'd1) ? ID1 : 8'h00;
            DOUT_STAT: rd_byte = {F_nWP, F_nRB, 5'b0, fail};
            default:   rd_byte = 8'h00;
        endcase
    end

    // Page register: preset to 0xFF on program setup, filled by data-in strobes.
    always_ff @(posedge PCLK) begin
        if (cmd_stb && !busy && F_DIO_I == 8'h80) begin
            for (int i = 0; i < PAGE_BYTES; i++) page_reg[i] <= 8'hFF;
        end else if (data_stb && !busy && state == DIN) begin
            page_reg[col] <= F_DIO_I;
        end
    end

    // Array write port; the array deliberately survives PRESET.
    always_ff @(posedge PCLK) begin
        if (copy_now)
            mem[page][cp_idx[CB-1:0]] <= copy_ers ? 8'hFF : page_reg[cp_idx[CB-1:0]];
    end

    // Main FSM: strobe decode, busy timer and registered pin outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            next_st  <= IDLE;
            nwe_q    <= 1'b1;
            nre_q    <= 1'b1;
            cmd      <= 8'h00;
            acnt     <= '0;
            col      <= '0;
            page     <= '0;
            id_ptr   <= '0;
            fail     <= 1'b0;
            timer    <= '0;
            copy_on  <= 1'b0;
            copy_ers <= 1'b0;
            cp_idx   <= '0;
            F_DIO_O  <= 8'h00;
            F_DIO_OE <= 1'b0;
            F_nRB    <= 1'b1;
        end else begin
            nwe_q <= F_nWE;
            nre_q <= F_nRE;

            // Busy countdown; a command below on the same edge overrides it.
            if (busy) begin
                if (copy_now) cp_idx <= cp_idx + 1'b1;
                if (timer == TW'(1)) begin
                    F_nRB   <= 1'b1;
                    copy_on <= 1'b0;
                    if (state == BUSY) state <= next_st;
                end
                timer <= timer - 1'b1;
            end

            if (cmd_stb) begin
                if (F_DIO_I == 8'hFF) begin
                    timer   <= TW'(T_RST);
                    F_nRB   <= 1'b0;
                    state   <= BUSY;
                    next_st <= IDLE;
                    copy_on <= 1'b0;
                end else if (F_DIO_I == 8'h70) begin
                    state <= DOUT_STAT;
                end else if (!busy) begin
                    case (F_DIO_I)
                        8'h00, 8'h80, 8'h90: begin
                            cmd   <= F_DIO_I;
                            state <= ADDR;
                            acnt  <= '0;
                        end
                        8'h30: begin
                            if (state == ADDR && cmd == 8'h00 && acnt == 3'd5) begin
                                timer   <= TW'(T_R);
                                F_nRB   <= 1'b0;
                                state   <= BUSY;
                                next_st <= DOUT_PAGE;
                            end else begin
                                state <= IDLE;
                            end
                        end
                        8'h10: begin
                            if (state == DIN && cmd == 8'h80) begin
                                if (!F_nWP) begin
                                    fail  <= 1'b1;
                                    state <= IDLE;
                                end else begin
                                    fail     <= 1'b0;
                                    timer    <= TW'(T_PROG);
                                    F_nRB    <= 1'b0;
                                    state    <= BUSY;
                                    next_st  <= IDLE;
                                    copy_on  <= 1'b1;
                                    copy_ers <= 1'b0;
                                    cp_idx   <= '0;
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end
`ifdef NAND_TARGET_ERASE_EN
                        8'h60: begin
                            cmd   <= F_DIO_I;
                            state <= ADDR;
                            acnt  <= '0;
                        end
                        8'hD0: begin
                            if (state == ADDR && cmd == 8'h60 && acnt == 3'd3) begin
                                if (!F_nWP) begin
                                    fail  <= 1'b1;
                                    state <= IDLE;
                                end else begin
                                    fail     <= 1'b0;
                                    timer    <= TW'(T_ERS);
                                    F_nRB    <= 1'b0;
                                    state    <= BUSY;
                                    next_st  <= IDLE;
                                    copy_on  <= 1'b1;
                                    copy_ers <= 1'b1;
                                    cp_idx   <= '0;
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end
`endif
                        default: state <= IDLE;
                    endcase
                end
            end else if (addr_stb && !busy && state == ADDR) begin
                case (cmd)
                    8'h90: begin
                        state  <= DOUT_ID;
                        id_ptr <= '0;
                    end
`ifdef NAND_TARGET_ERASE_EN
                    8'h60: begin
                        // Erase takes row cycles only; row0 carries the page.
                        if (acnt == 3'd0) page <= F_DIO_I[PB-1:0];
                        if (acnt != 3'd3) acnt <= acnt + 1'b1;
                    end
`endif
                    default: begin
                        // col0, col1, row0, row1, row2; surplus cycles ignored.
                        if (acnt == 3'd0) col  <= F_DIO_I[CB-1:0];
                        if (acnt == 3'd2) page <= F_DIO_I[PB-1:0];
                        if (acnt != 3'd5) acnt <= acnt + 1'b1;
                        if (cmd == 8'h80 && acnt == 3'd4) state <= DIN;
                    end
                endcase
            end else if (data_stb && !busy && state == DIN) begin
                col <= col + 1'b1;
            end

            // Read side: load on nRE fall, advance on nRE rise.
            if (F_nCE || F_nRE) F_DIO_OE <= 1'b0;
            if (re_fall && dout) begin
                F_DIO_O  <= rd_byte;
                F_DIO_OE <= 1'b1;
            end
            if (re_rise) begin
                if (state == DOUT_PAGE) col <= col + 1'b1;
                if (state == DOUT_ID && id_ptr != 2'd2) id_ptr <= id_ptr + 1'b1;
            end
        end
    end
endmodule
